// File: rtl/fwd_scoreboard_pkg.sv
// rtl/fwd_scoreboard_pkg.sv - shared FSM states, instruction field positions and helpers
package fwd_scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_ERR   = 2'd2
  } state_e;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RS3_LSB = 27;
  localparam int RD_LSB  = 7;
  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic logic [4:0] src_reg(input logic [31:0] instr, input int port);
    case (port)
      0:       src_reg = instr[RS1_LSB +: 5];
      1:       src_reg = instr[RS2_LSB +: 5];
      default: src_reg = instr[RS3_LSB +: 5];
    endcase
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    popcount = '0;
    for (int i = 0; i < 32; i++) popcount = popcount + {5'd0, v[i]};
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - EX operand, bypass-stage and long-latency completion bundle
interface fwd_scoreboard_if #(
  parameter int XLEN           = 32,
  parameter int NUM_RD_PORTS   = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int MAX_PEND       = 4
);
  localparam int PW = $clog2(MAX_PEND + 1);

  logic                           ex_valid;
  logic [31:0]                    ex_instr;
  logic [NUM_RD_PORTS-1:0]        ex_rd_used;
  logic                           ex_long;
  logic [NUM_RD_PORTS*XLEN-1:0]   rf_data;
  logic [NUM_FWD_STAGES-1:0]      stg_we;
  logic [NUM_FWD_STAGES*5-1:0]    stg_rd;
  logic [NUM_FWD_STAGES*XLEN-1:0] stg_data;
  logic                           ld_done;
  logic [4:0]                     ld_rd;
  logic [XLEN-1:0]                ld_data;
  logic                           flush;
  logic [NUM_RD_PORTS*XLEN-1:0]   fwd_data;
  logic                           stall;
  logic [PW-1:0]                  pend_cnt;
  logic                           err;

  modport master (
    output ex_valid, ex_instr, ex_rd_used, ex_long, rf_data, stg_we, stg_rd, stg_data,
           ld_done, ld_rd, ld_data, flush,
    input  fwd_data, stall, pend_cnt, err
  );

  modport slave (
    input  ex_valid, ex_instr, ex_rd_used, ex_long, rf_data, stg_we, stg_rd, stg_data,
           ld_done, ld_rd, ld_data, flush,
    output fwd_data, stall, pend_cnt, err
  );
endinterface

// File: rtl/fwd_mux_port.sv
// rtl/fwd_mux_port.sv - per-read-port operand select: completion, then youngest stage, then RF
module fwd_mux_port
  import fwd_scoreboard_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_FWD_STAGES = 2
) (
  input  logic [4:0]                     rs,
  input  logic [XLEN-1:0]                rf,
  input  logic [NUM_FWD_STAGES-1:0]      stg_we,
  input  logic [NUM_FWD_STAGES*5-1:0]    stg_rd,
  input  logic [NUM_FWD_STAGES*XLEN-1:0] stg_data,
  input  logic                           ld_done,
  input  logic [4:0]                     ld_rd,
  input  logic [XLEN-1:0]                ld_data,
  output logic [XLEN-1:0]                data
);

  always_comb begin
    data = rf;
    if (rs != REG_X0) begin
      // oldest first so a younger matching stage overwrites it
      for (int s = NUM_FWD_STAGES - 1; s >= 0; s--) begin
        if (stg_we[s] && (stg_rd[s*5 +: 5] == rs)) data = stg_data[s*XLEN +: XLEN];
      end
      if (ld_done && (ld_rd == rs)) data = ld_data;
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - operand bypass plus long-latency write scoreboard with stall timeout
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_RD_PORTS   = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int MAX_PEND       = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic            clk,
  input  logic            rst,
  fwd_scoreboard_if.slave bus
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [31:0]     busy_q, busy_d;
  logic [4:0]      rd;
  logic [PW-1:0]   pend;
  logic            ld_hit, raw_haz, waw_haz, full_haz, hazard, issue, stall;
  logic [XLEN-1:0] fwd_arr [NUM_RD_PORTS];

  assign rd     = bus.ex_instr[RD_LSB +: 5];
  assign pend   = PW'(popcount(busy_q));
  // bit 0 is never set, so this also excludes x0
  assign ld_hit = bus.ld_done && busy_q[bus.ld_rd];
  assign issue  = bus.ex_valid && !stall && bus.ex_long && (rd != REG_X0) && !bus.flush;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    fwd_mux_port #(
      .XLEN          (XLEN),
      .NUM_FWD_STAGES(NUM_FWD_STAGES)
    ) u_mux (
      .rs      (src_reg(bus.ex_instr, p)),
      .rf      (bus.rf_data[p*XLEN +: XLEN]),
      .stg_we  (bus.stg_we),
      .stg_rd  (bus.stg_rd),
      .stg_data(bus.stg_data),
      .ld_done (bus.ld_done),
      .ld_rd   (bus.ld_rd),
      .ld_data (bus.ld_data),
      .data    (fwd_arr[p])
    );
  end

  always_comb begin
    bus.fwd_data = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) bus.fwd_data[p*XLEN +: XLEN] = fwd_arr[p];
  end

  // a completion landing this cycle resolves RAW, WAW and capacity hazards on it
  always_comb begin
    raw_haz = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (bus.ex_rd_used[p] && busy_q[src_reg(bus.ex_instr, p)] &&
          !(ld_hit && (bus.ld_rd == src_reg(bus.ex_instr, p)))) raw_haz = 1'b1;
    end
    waw_haz  = bus.ex_long && busy_q[rd] && !(ld_hit && (bus.ld_rd == rd));
    full_haz = bus.ex_long && (pend == PW'(MAX_PEND)) && !ld_hit;
    hazard   = bus.ex_valid && (raw_haz || waw_haz || full_haz);
  end

  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (ld_hit) busy_d[bus.ld_rd] = 1'b0;
      if (issue)  busy_d[rd]        = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (hazard) begin
          state_d = ST_STALL;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d = '0;
        end
      end
      ST_STALL: begin
        if (!hazard) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CW'(TIMEOUT)) state_d = ST_ERR;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
    if (bus.flush) begin
      cnt_d = '0;
      if (state_q != ST_ERR) state_d = ST_RUN;
    end
  end

  always_comb begin
    stall        = (state_q == ST_ERR) ? 1'b1 : hazard;
    bus.stall    = stall;
    bus.err      = (state_q == ST_ERR);
    bus.pend_cnt = pend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed stimulus with a per-cycle reference model for fwd_scoreboard
module tb_fwd_scoreboard;
  import fwd_scoreboard_pkg::*;

  localparam int XLEN = 32;
  localparam int NRP  = 3;
  localparam int NFS  = 2;
  localparam int MAXP = 4;
  localparam int TMO  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.XLEN(XLEN), .NUM_RD_PORTS(NRP), .NUM_FWD_STAGES(NFS), .MAX_PEND(MAXP)) bus ();

  fwd_scoreboard #(
    .XLEN(XLEN), .NUM_RD_PORTS(NRP), .NUM_FWD_STAGES(NFS), .MAX_PEND(MAXP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2, input int rs3);
    return 32'(((rs3 & 31) << 27) | ((rs2 & 31) << 20) | ((rs1 & 31) << 15) | ((rd & 31) << 7));
  endfunction

  function automatic int fld(input logic [31:0] ins, input int lsb);
    return int'((ins >> lsb) & 32'd31);
  endfunction

  function automatic int src_of(input logic [31:0] ins, input int p);
    return fld(ins, (p == 0) ? 15 : (p == 1) ? 20 : 27);
  endfunction

  // reference model: set of pending destination registers, consecutive stalled cycles, sticky error
  bit          m_busy [32];
  bit          m_err;
  int          m_run;
  int          m_rd, m_cnt, m_r;
  bit          m_done, m_hz, m_found;
  logic [31:0] m_e;

  always @(negedge clk) begin
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_err = 1'b0;
      m_run = 0;
    end else begin
      m_rd   = fld(bus.ex_instr, 7);
      m_done = bus.ld_done && m_busy[bus.ld_rd];
      m_cnt  = 0;
      foreach (m_busy[i]) m_cnt += int'(m_busy[i]);
      m_hz = 1'b0;
      for (int p = 0; p < NRP; p++) begin
        m_r = src_of(bus.ex_instr, p);
        if (bus.ex_rd_used[p] && m_busy[m_r] && !(m_done && bus.ld_rd == m_r)) m_hz = 1'b1;
        m_e = bus.rf_data[p*XLEN +: XLEN];
        if (m_r != 0) begin
          if (bus.ld_done && bus.ld_rd == m_r) begin
            m_e = bus.ld_data;
          end else begin
            m_found = 1'b0;
            for (int s = 0; s < NFS; s++) begin
              if (!m_found && bus.stg_we[s] && bus.stg_rd[s*5 +: 5] == m_r) begin
                m_e = bus.stg_data[s*XLEN +: XLEN];
                m_found = 1'b1;
              end
            end
          end
        end
        chk($sformatf("fwd%0d", p), bus.fwd_data[p*XLEN +: XLEN], m_e);
      end
      if (bus.ex_long && m_busy[m_rd] && !(m_done && bus.ld_rd == m_rd)) m_hz = 1'b1;
      if (bus.ex_long && m_cnt == MAXP && !m_done) m_hz = 1'b1;
      m_hz = m_hz && bus.ex_valid;
      chk("stall", 32'(bus.stall), 32'(m_err || m_hz));
      chk("pend_cnt", 32'(bus.pend_cnt), 32'(m_cnt));
      chk("err", 32'(bus.err), 32'(m_err));
      if (bus.flush) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_run = 0;
      end else begin
        if (m_done) m_busy[bus.ld_rd] = 1'b0;
        if (bus.ex_valid && !(m_err || m_hz) && bus.ex_long && m_rd != 0) m_busy[m_rd] = 1'b1;
        if (!m_err) begin
          if (m_hz) begin
            m_run++;
            if (m_run >= TMO) m_err = 1'b1;
          end else begin
            m_run = 0;
          end
        end
      end
    end
  end

  task automatic idle();
    bus.ex_valid   = 1'b0;
    bus.ex_instr   = '0;
    bus.ex_rd_used = '0;
    bus.ex_long    = 1'b0;
    bus.rf_data    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    bus.stg_we     = '0;
    bus.stg_rd     = '0;
    bus.stg_data   = '0;
    bus.ld_done    = 1'b0;
    bus.ld_rd      = '0;
    bus.ld_data    = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic prio_setup();
    bus.ex_valid   = 1'b1;
    bus.ex_instr   = mk(0, 5, 0, 6);
    bus.ex_rd_used = 3'b101;
    bus.stg_we     = 2'b11;
    bus.stg_rd     = {5'd5, 5'd5};
    bus.stg_data   = {32'hB, 32'hA};
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    settle();
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_pend", 32'(bus.pend_cnt), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    adv();

    prio_setup();
    settle();
    chk("prio_stg0", bus.fwd_data[31:0], 32'hA);
    chk("x0_rf_port1", bus.fwd_data[63:32], 32'h2222_2222);
    chk("rf_port2", bus.fwd_data[95:64], 32'h3333_3333);
    adv();
    prio_setup();
    bus.ld_done = 1'b1;
    bus.ld_rd   = 5'd5;
    bus.ld_data = 32'hC;
    settle();
    chk("prio_ld", bus.fwd_data[31:0], 32'hC);
    chk("ld_nonbusy_pend", 32'(bus.pend_cnt), 32'd0);
    adv();
    prio_setup();
    bus.stg_we = 2'b10;
    settle();
    chk("prio_stg1", bus.fwd_data[31:0], 32'hB);
    adv();

    bus.ex_valid   = 1'b1;
    bus.ex_instr   = mk(0, 0, 0, 6);
    bus.ex_rd_used = 3'b101;
    bus.rf_data    = {32'h3333_3333, 32'h2222_2222, 32'h0};
    bus.stg_we     = 2'b11;
    bus.stg_rd     = {5'd6, 5'd0};
    bus.stg_data   = {32'h66, 32'hFFFF};
    settle();
    chk("x0_rule", bus.fwd_data[31:0], 32'h0);
    chk("rs3_stg1", bus.fwd_data[95:64], 32'h66);
    adv();

    bus.ex_valid = 1'b1;
    bus.ex_long  = 1'b1;
    bus.ex_instr = mk(7, 0, 0, 0);
    settle();
    chk("c_issue_stall", 32'(bus.stall), 32'd0);
    adv();
    bus.ex_valid   = 1'b1;
    bus.ex_instr   = mk(1, 0, 7, 0);
    bus.ex_rd_used = 3'b010;
    settle();
    chk("c_pend1", 32'(bus.pend_cnt), 32'd1);
    chk("c_raw_stall", 32'(bus.stall), 32'd1);
    adv();
    bus.ex_valid   = 1'b1;
    bus.ex_instr   = mk(1, 0, 7, 0);
    bus.ex_rd_used = 3'b010;
    bus.ld_done    = 1'b1;
    bus.ld_rd      = 5'd7;
    bus.ld_data    = 32'h55;
    settle();
    chk("c_fsm_stall", 32'(dut.state_q), 32'(ST_STALL));
    chk("c_stall_clear", 32'(bus.stall), 32'd0);
    chk("c_fwd1", bus.fwd_data[63:32], 32'h55);
    adv();
    settle();
    chk("c_fsm_run", 32'(dut.state_q), 32'(ST_RUN));
    chk("c_pend0", 32'(bus.pend_cnt), 32'd0);
    adv();

    for (int i = 1; i <= 4; i++) begin
      bus.ex_valid = 1'b1;
      bus.ex_long  = 1'b1;
      bus.ex_instr = mk(i, 0, 0, 0);
      settle();
      adv();
    end
    settle();
    chk("d_pend4", 32'(bus.pend_cnt), 32'd4);
    adv();
    bus.ex_valid = 1'b1;
    bus.ex_long  = 1'b1;
    bus.ex_instr = mk(5, 0, 0, 0);
    settle();
    chk("d_full_stall", 32'(bus.stall), 32'd1);
    adv();
    bus.ex_valid = 1'b1;
    bus.ex_long  = 1'b1;
    bus.ex_instr = mk(5, 0, 0, 0);
    bus.ld_done  = 1'b1;
    bus.ld_rd    = 5'd2;
    settle();
    chk("d_fifth_issues", 32'(bus.stall), 32'd0);
    adv();
    settle();
    chk("d_pend_stays4", 32'(bus.pend_cnt), 32'd4);
    adv();
    bus.flush = 1'b1;
    settle();
    adv();
    settle();
    chk("d_flush_pend0", 32'(bus.pend_cnt), 32'd0);
    adv();

    bus.ex_valid = 1'b1;
    bus.ex_long  = 1'b1;
    bus.ex_instr = mk(3, 0, 0, 0);
    settle();
    adv();
    bus.ex_valid = 1'b1;
    bus.ex_long  = 1'b1;
    bus.ex_instr = mk(3, 0, 0, 0);
    bus.ld_done  = 1'b1;
    bus.ld_rd    = 5'd3;
    settle();
    chk("e_collide_issue", 32'(bus.stall), 32'd0);
    adv();
    bus.ex_valid   = 1'b1;
    bus.ex_instr   = mk(0, 3, 0, 0);
    bus.ex_rd_used = 3'b001;
    settle();
    chk("e_pend_same", 32'(bus.pend_cnt), 32'd1);
    chk("e_busy3_stall", 32'(bus.stall), 32'd1);
    adv();
    bus.ex_valid = 1'b1;
    bus.ex_long  = 1'b1;
    bus.ex_instr = mk(8, 0, 0, 0);
    bus.flush    = 1'b1;
    settle();
    adv();
    bus.ex_valid   = 1'b1;
    bus.ex_instr   = mk(0, 8, 3, 0);
    bus.ex_rd_used = 3'b011;
    settle();
    chk("e_flush_pend0", 32'(bus.pend_cnt), 32'd0);
    chk("e_flush_nostall", 32'(bus.stall), 32'd0);
    adv();

    bus.ex_valid = 1'b1;
    bus.ex_long  = 1'b1;
    bus.ex_instr = mk(9, 0, 0, 0);
    settle();
    adv();
    for (int c = 1; c <= 4; c++) begin
      bus.ex_valid   = 1'b1;
      bus.ex_instr   = mk(0, 9, 0, 0);
      bus.ex_rd_used = 3'b001;
      settle();
      chk($sformatf("f_stall_c%0d", c), 32'(bus.stall), 32'd1);
      chk($sformatf("f_err_c%0d", c), 32'(bus.err), (c == 4) ? 32'd1 : 32'd0);
      adv();
    end
    bus.flush = 1'b1;
    settle();
    chk("f_flush_err", 32'(bus.err), 32'd1);
    adv();
    settle();
    chk("f_err_sticky", 32'(bus.err), 32'd1);
    chk("f_err_stall", 32'(bus.stall), 32'd1);
    chk("f_flush_pend", 32'(bus.pend_cnt), 32'd0);
    adv();
    rst = 1'b1;
    settle();
    adv();
    rst = 1'b0;
    settle();
    chk("f_rst_err", 32'(bus.err), 32'd0);
    chk("f_rst_stall", 32'(bus.stall), 32'd0);
    adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter XLEN, default 32: datapath width.
REQ-002 Parameter NUM_RD_PORTS, default 2 (range 1-3): source operands; port0 rs1=[19:15], port1 rs2=[24:20], port2 rs3=[31:27].
REQ-003 Parameter NUM_FWD_STAGES, default 2 (range 1-4): bypass sources; index 0 is youngest.
REQ-004 Parameter MAX_PEND, default 4: maximum outstanding long-latency writes.
REQ-005 Parameter TIMEOUT, default 255: stall cycles before error.
REQ-006 Port clk  in  1  clock; one clock domain, all state on rising edge.
REQ-007 Port rst  in  1  synchronous, active-high reset.
REQ-008 Port ex_valid  in  1  EX instruction presented.
REQ-009 Port ex_instr  in  32  EX instruction; rd=[11:7].
REQ-010 Port ex_rd_used  in  NUM_RD_PORTS  per-port operand-used mask.
REQ-011 Port ex_long  in  1  EX instruction writes rd via long-latency unit.
REQ-012 Port rf_data  in  NUM_RD_PORTS*XLEN  register-file operands.
REQ-013 Port stg_we  in  NUM_FWD_STAGES  stage write enables.
REQ-014 Port stg_rd  in  NUM_FWD_STAGES*5  stage destination registers.
REQ-015 Port stg_data  in  NUM_FWD_STAGES*XLEN  stage result data.
REQ-016 Port ld_done  in  1  long-latency completion strobe.
REQ-017 Port ld_rd  in  5  completing register.
REQ-018 Port ld_data  in  XLEN  completing data.
REQ-019 Port flush  in  1  kill all pending long writes.
REQ-020 Port fwd_data  out  NUM_RD_PORTS*XLEN  forwarded operands (combinational).
REQ-021 Port stall  out  1  hold EX; instruction not issued.
REQ-022 Port pend_cnt  out  $clog2(MAX_PEND+1)  outstanding long writes.
REQ-023 Port err  out  1  sticky stall timeout.

Function
REQ-024 Operand priority per port: ld_done match, then stage 0, then stage 1 onward, then rf_data.
REQ-025 A source matches only if its enable is high, rd equals the port's register, and the register is nonzero; x0 SHALL always yield rf_data.
REQ-026 busy[31:1] scoreboard: set on issue (ex_valid & ~stall & ex_long & rd!=0); cleared when ld_done hits a busy ld_rd.
REQ-027 ld_done to a non-busy register SHALL be ignored for scoreboard purposes; its data is still bypassed.
REQ-028 Hazard when ex_valid and any of the following holds:
- a used port reads a busy register not completing this cycle;
- ex_long with rd busy (WAW);
- ex_long with pend_cnt==MAX_PEND.
REQ-029 stall SHALL equal the hazard term, combinationally, in states RUN and STALL; stall SHALL be 1 in state ERR.
REQ-030 Same-cycle issue and ld_done on the same rd: set wins, and pend_cnt is unchanged.
REQ-031 pend_cnt SHALL equal popcount(busy) at all times and never exceed MAX_PEND.
REQ-032 FSM states RUN, STALL, ERR.
- RUN to STALL on hazard.
- STALL to RUN when the hazard clears.
- STALL to ERR when the stall counter reaches TIMEOUT.
REQ-033 The stall counter SHALL increment each STALL cycle, saturate, and clear on entering RUN.
REQ-034 flush SHALL clear busy, pend_cnt and the stall counter, and move the FSM to RUN the next cycle; it SHALL NOT clear ERR.
REQ-035 flush has priority over a same-cycle issue, which then sets no busy bit.
REQ-036 err=1 exactly while in ERR; ERR exits only by rst.

Reset
REQ-037 On rst, the block SHALL reach the following state the next cycle:
- busy=0, pend_cnt=0, counter=0;
- FSM=RUN, stall=0 (absent a hazard), err=0.
REQ-038 rst SHALL override flush and all other inputs.

Structure
REQ-039 A shared package SHALL hold the FSM state enum, RS1/RS2/RS3/RD bit-field constants, and REG_X0.
REQ-040 One sub-module, fwd_mux_port, SHALL be instantiated per read port and implement REQ-024/025.

Verification
REQ-041 Bypass priority: stg_we=2'b11, stg_rd={5,5}, stg_data0=0xA, stg_data1=0xB, rs1=5 -> fwd_data port0=0xA; with ld_done rd=5 data=0xC the result is 0xC.
REQ-042 x0 rule: stg_we[0]=1, stg_rd0=0, data=0xFFFF, rs1=0, rf_data=0 -> fwd=0.
REQ-043 Scoreboard sequence:
- issue long rd=7 -> pend_cnt=1.
- Next instruction uses rs2=7 -> stall=1, FSM=STALL.
- ld_done rd=7 data=0x55 -> same cycle stall=0, fwd port1=0x55; next cycle FSM=RUN, pend_cnt=0.
REQ-044 Capacity: issue 4 long ops to r1-r4 -> pend_cnt=4; a fifth long op stalls; ld_done r2 -> the fifth issues and pend_cnt stays 4.
REQ-045 Timeout: TIMEOUT=3, hold a dependent instruction on busy r9 -> err=1 on the 4th stall cycle, stall=1; flush keeps err=1; rst clears it.
REQ-046 Collision: same-cycle issue long rd=3 with ld_done rd=3 -> busy[3]=1 afterwards; flush during issue -> busy=0, pend_cnt=0.
